// File: rtl/mips_fetch.sv
// mips_fetch: PC, credit-limited imem requests and in-order instruction buffer feeding decode
module mips_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] imm_sext
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outst_q, outst_d, disc_q, disc_d, cnt_q, cnt_d, occ;
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d, sw_q, sw_d, sr_q, sr_d;
    logic [31:0]   ins_mem [DEPTH];
    logic [31:0]   pcb_mem [DEPTH];
    logic [31:0]   spc_mem [DEPTH];
    logic          gnt, rsp, pop, push;

    assign gnt  = imem_req && imem_gnt;
    assign rsp  = imem_rvalid && outst_q != '0;
    assign pop  = cnt_q != '0 && dec_ready;
    assign push = rsp && state_q == RUN && !redirect_valid;
    assign occ  = cnt_q - CW'(pop);

    // State register: FSM, PC, counters and pointers, all cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            outst_q <= '0;
            disc_q  <= '0;
            cnt_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            sw_q    <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            outst_q <= outst_d;
            disc_q  <= disc_d;
            cnt_q   <= cnt_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            sw_q    <= sw_d;
            sr_q    <= sr_d;
        end
    end

    // Storage: instruction buffer with its PCs, and the PC of every granted request in order
    always_ff @(posedge clk) begin
        if (push) begin
            ins_mem[wp_q] <= imem_rdata;
            pcb_mem[wp_q] <= spc_mem[sr_q];
        end
        if (gnt)
            spc_mem[sw_q] <= pc_q;
    end

    // Datapath next state: a redirect drops this cycle's response and counts any grant as stale
    always_comb begin
        outst_d = outst_q + CW'(gnt) - CW'(rsp);
        disc_d  = redirect_valid ? outst_d : (state_q == FLUSH && rsp) ? disc_q - CW'(1) : disc_q;
        pc_d    = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : gnt ? pc_q + 32'd4 : pc_q;
        cnt_d   = redirect_valid ? '0 : cnt_q + CW'(push) - CW'(pop);
        wp_d    = redirect_valid ? '0 : wp_q + AW'(push);
        rp_d    = redirect_valid ? '0 : rp_q + AW'(pop);
        sw_d    = redirect_valid ? '0 : sw_q + AW'(gnt);
        sr_d    = redirect_valid ? '0 : sr_q + AW'(push);
    end

    // FSM next state: FLUSH while stale responses remain, RUN once the last one is dropped
    always_comb begin
        state_d = redirect_valid ? (disc_d != '0 ? FLUSH : RUN)
                : (state_q == FLUSH && disc_d == '0) ? RUN : state_q;
    end

    // Outputs: request only within credit (outstanding plus post-pop occupancy below DEPTH)
    always_comb begin
        imem_req  = !rst && state_q == RUN && ({1'b0, outst_q} + {1'b0, occ}) < DEPTH_C;
        dec_valid = cnt_q != '0;
    end

    assign imem_addr = pc_q;
    assign dec_instr = ins_mem[rp_q];
    assign dec_pc    = pcb_mem[rp_q];
    assign opcode    = dec_instr[31:26];
    assign rs        = dec_instr[25:21];
    assign rt        = dec_instr[20:16];
    assign rd        = dec_instr[15:11];
    assign funct     = dec_instr[5:0];
    assign imm_sext  = {{16{dec_instr[15]}}, dec_instr[15:0]};

    // A response with nothing outstanding violates the memory protocol and is ignored
    assert property (@(posedge clk) disable iff (rst) imem_rvalid |-> outst_q != '0);
endmodule

// File: tb/tb_mips_fetch.sv
// tb_mips_fetch: directed scoreboard bench for mips_fetch with a budgeted instruction memory model
module tb_mips_fetch;
    logic        clk = 1'b0;
    logic        rst, imem_req, imem_gnt, imem_rvalid, redirect_valid, dec_valid, dec_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, dec_instr, dec_pc, imm_sext;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    int          tests = 0, fails = 0, budget = 0, cyc = 0, grants = 0, pops = 0;
    int          first_gnt = -1, first_dv = -1, last_pop = -1;
    bit          rsp_hold = 1'b0;
    logic [31:0] pend[$], exp_q[$];
    logic [31:0] mon_pc, mon_ins;

    mips_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
        .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .imm_sext(imm_sext)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h40) ? 32'h8C43_FFF8 : (a == 32'h44) ? 32'h0085_3020 : a ^ 32'hC3A5_96E1;
    endfunction

    // Memory model: grants while budget remains, answers in order one or more cycles after grant
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
            pend.delete();
        end else begin
            imem_gnt = budget > 0;
            if (!rsp_hold && pend.size() > 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem(pend.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
            #1;
            if (imem_req && imem_gnt) begin
                pend.push_back(imem_addr);
                budget--;
                grants++;
                if (first_gnt < 0) first_gnt = cyc;
            end
        end
    end

    // Monitor: every consumed instruction is compared against the head of the expected queue
    always @(negedge clk) begin
        #1;
        if (!rst && dec_valid && first_dv < 0) first_dv = cyc;
        if (!rst && dec_valid && dec_ready) begin
            pops++;
            last_pop = cyc;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pop: dec_pc=%h dec_instr=%h, required no instruction", dec_pc, dec_instr);
            end else begin
                mon_pc  = exp_q.pop_front();
                mon_ins = mem(mon_pc);
                if (dec_pc !== mon_pc || dec_instr !== mon_ins) begin
                    fails++;
                    $display("FAIL pop: dec_pc=%h dec_instr=%h, required pc=%h instr=%h", dec_pc, dec_instr, mon_pc, mon_ins);
                end
                tests++;
                if ({opcode, rs, rt, rd, funct} !== {mon_ins[31:26], mon_ins[25:21], mon_ins[20:16], mon_ins[15:11], mon_ins[5:0]}
                    || imm_sext !== {{16{mon_ins[15]}}, mon_ins[15:0]}) begin
                    fails++;
                    $display("FAIL fields: pc=%h op=%h rs=%0d rt=%0d rd=%0d fn=%h imm=%h, required split of %h",
                             mon_pc, opcode, rs, rt, rd, funct, imm_sext, mon_ins);
                end
                if (mon_pc == 32'h40) begin
                    tests++;
                    if (opcode !== 6'h23 || rs !== 5'd2 || rt !== 5'd3 || imm_sext !== 32'hFFFF_FFF8) begin
                        fails++;
                        $display("FAIL lw_fields: op=%h rs=%0d rt=%0d imm=%h, required 23 2 3 fffffff8", opcode, rs, rt, imm_sext);
                    end
                end
                if (mon_pc == 32'h44) begin
                    tests++;
                    if (opcode !== 6'h00 || rs !== 5'd4 || rt !== 5'd5 || rd !== 5'd6 || funct !== 6'h20) begin
                        fails++;
                        $display("FAIL r_fields: op=%h rs=%0d rt=%0d rd=%0d fn=%h, required 00 4 5 6 20", opcode, rs, rt, rd, funct);
                    end
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic wait_budget();
        int n = 0;
        while (budget != 0 && n < 50) begin
            step();
            n++;
        end
        check("grant_wait_remaining", budget, 0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((budget != 0 || pend.size() != 0 || exp_q.size() != 0) && n < 300) begin
            step();
            n++;
        end
        check("drain_missing_instrs", exp_q.size(), 0);
        step(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; dec_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        step(3);
        check("reset_imem_req", imem_req, 0);
        check("reset_dec_valid", dec_valid, 0);
        check("reset_addr", imem_addr, 32'h0);
        // Streaming from RESET_PC, one grant and one response per cycle
        for (int i = 0; i < 20; i++) exp_q.push_back(32'(4 * i));
        rst = 1'b0; budget = 20;
        wait_drain();
        check("first_valid_latency", first_dv - first_gnt, 2);
        check("sustained_rate", last_pop - first_dv, 19);
        // Decode stall: credit caps in-flight plus buffered at DEPTH
        for (int i = 0; i < 12; i++) exp_q.push_back(32'h50 + 32'(4 * i));
        budget = 12;
        step(3);
        dec_ready = 1'b0;
        step(5);
        check("stall_imem_req", imem_req, 0);
        check("stall_inflight", grants - pops, 2);
        dec_ready = 1'b1;
        wait_drain();
        // Redirect with two requests outstanding, unaligned target
        rsp_hold = 1'b1; budget = 2;
        wait_budget();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        check("flush_imem_req", imem_req, 0);
        check("redirect_addr", imem_addr, 32'h0000_0100);
        check("redirect_dec_valid", dec_valid, 0);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(4 * i));
        rsp_hold = 1'b0; budget = 4;
        wait_drain();
        // Redirect coinciding with a grant and a response
        rsp_hold = 1'b1; budget = 1;
        wait_budget();
        rsp_hold = 1'b0; budget = 1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        check("same_cycle_flush_req", imem_req, 0);
        check("same_cycle_stale_grant", pend.size(), 1);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h200 + 32'(4 * i));
        budget = 3;
        wait_drain();
        // Redirect to the top word: PC wraps to zero
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        check("wrap_run_req", imem_req, 1);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        budget = 2;
        wait_drain();
        // Full buffer, redirect while popping: the head is delivered, the rest dropped
        dec_ready = 1'b0; budget = 2;
        exp_q.push_back(32'h4);
        wait_budget();
        step();
        check("full_dec_valid", dec_valid, 1);
        check("full_imem_req", imem_req, 0);
        dec_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        step();
        redirect_valid = 1'b0;
        check("pop_redirect_dec_valid", dec_valid, 0);
        check("pop_redirect_head_taken", exp_q.size(), 0);
        exp_q.push_back(32'h300);
        budget = 1;
        wait_drain();
        // Asynchronous reset with a full buffer
        dec_ready = 1'b0; budget = 2;
        wait_budget();
        step();
        rst = 1'b1;
        #1;
        check("async_rst_dec_valid", dec_valid, 0);
        check("async_rst_imem_req", imem_req, 0);
        step();
        check("rst_held_imem_req", imem_req, 0);
        rst = 1'b0; dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'(4 * i));
        budget = 3;
        wait_drain();
        // Asynchronous reset while flushing: fetch restarts at RESET_PC
        rsp_hold = 1'b1; budget = 2;
        wait_budget();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0500;
        step();
        redirect_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("flush_rst_imem_req", imem_req, 0);
        check("flush_rst_addr", imem_addr, 32'h0);
        rsp_hold = 1'b0;
        step(2);
        rst = 1'b0;
        exp_q.push_back(32'h0);
        budget = 1;
        wait_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
